cpu_writeback_stage: RTL and testbench

Memory/writeback stage of the CPU pipeline: consumes toggle-strobed packets from the execute stage, performs load/store accesses on the data bus with a request/ready handshake, and produces the toggle-strobed register write-back packet consumed by the register file. It is the producer end of the 39-bit write-back interface (strobe, rd, data). Load data is aligned and sign/zero-extended here; store data is lane-replicated and byte-masked.

---
 rtl/cpu_writeback_stage.sv | 188 ++++++++++++++++++
 tb/tb_cpu_writeback_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_writeback_stage.sv
`default_nettype none
// =============================================================================
// cpu_writeback_stage : load/store bus access and register write-back packets
// Revision 1.0 - initial release
// =============================================================================
module cpu_writeback_stage (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [75:0] i_execute_data,
  output logic        o_busy,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wmask,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [38:0] o_memory_data,
  output logic        o_fault
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_last_strobe;
  logic        r_fault;
  logic        r_rw;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [5:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [38:0] r_mem_data;

  logic        w_strobe;
  logic [5:0]  w_rd;
  logic [31:0] w_result;
  logic [31:0] w_store_src;
  logic [2:0]  w_funct3;
  logic        w_mem_read;
  logic        w_mem_write;

  assign w_strobe    = i_execute_data[75];
  assign w_rd        = i_execute_data[74:69];
  assign w_result    = i_execute_data[68:37];
  assign w_store_src = i_execute_data[36:5];
  assign w_funct3    = i_execute_data[4:2];
  assign w_mem_read  = i_execute_data[1];
  assign w_mem_write = i_execute_data[0];

  logic w_accept;
  logic w_is_mem;
  logic w_legal;
  logic w_fault_op;
  logic w_start;

  assign w_accept = (r_state == S_IDLE) && (w_strobe != r_last_strobe);
  assign w_is_mem = w_mem_read | w_mem_write;

  // Width/alignment legality; loads additionally allow the unsigned variants.
  always_comb begin
    w_legal = 1'b0;
    case (w_funct3)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = ~w_result[0];
      3'b010:  w_legal = (w_result[1:0] == 2'b00);
      3'b100:  w_legal = w_mem_read;
      3'b101:  w_legal = w_mem_read & ~w_result[0];
      default: w_legal = 1'b0;
    endcase
  end

  assign w_fault_op = w_is_mem && ((w_mem_read & w_mem_write) || !w_legal);
  assign w_start    = w_accept && w_is_mem && !w_fault_op;

  logic [31:0] w_store_data;
  logic [3:0]  w_store_mask;

  always_comb begin
    w_store_data = w_store_src;
    w_store_mask = 4'b1111;
    case (w_funct3)
      3'b000: begin
        w_store_data = {4{w_store_src[7:0]}};
        w_store_mask = 4'b0001 << w_result[1:0];
      end
      3'b001: begin
        w_store_data = {2{w_store_src[15:0]}};
        w_store_mask = w_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_store_data = w_store_src;
        w_store_mask = 4'b1111;
      end
    endcase
  end

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  always_comb begin
    w_byte = i_bus_rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    w_load_ext = i_bus_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_BUS;
      S_BUS:   if (i_bus_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last_strobe <= 1'b0;
      r_fault       <= 1'b0;
      r_rw          <= 1'b0;
      r_address     <= 32'd0;
      r_wdata       <= 32'd0;
      r_wmask       <= 4'd0;
      r_rd          <= 6'd0;
      r_funct3      <= 3'd0;
      r_lane        <= 2'd0;
      r_mem_data    <= 39'd0;
    end else begin
      r_fault <= 1'b0;
      if (w_accept) begin
        r_last_strobe <= w_strobe;
        if (!w_is_mem) begin
          if (w_rd != 6'd0) r_mem_data <= {~r_mem_data[38], w_rd, w_result};
        end else if (w_fault_op) begin
          r_fault <= 1'b1;
        end else begin
          r_rw      <= w_mem_write;
          r_address <= {w_result[31:2], 2'b00};
          r_wdata   <= w_mem_write ? w_store_data : 32'd0;
          r_wmask   <= w_mem_write ? w_store_mask : 4'd0;
          r_rd      <= w_rd;
          r_funct3  <= w_funct3;
          r_lane    <= w_result[1:0];
        end
      end
      // Bus fields stay frozen after completion; only the write-back changes.
      if ((r_state == S_BUS) && i_bus_ready && !r_rw && (r_rd != 6'd0)) begin
        r_mem_data <= {~r_mem_data[38], r_rd, w_load_ext};
      end
    end
  end

  assign o_busy        = (r_state == S_BUS);
  assign o_bus_request = (r_state == S_BUS);
  assign o_bus_rw      = r_rw;
  assign o_bus_address = r_address;
  assign o_bus_wdata   = r_wdata;
  assign o_bus_wmask   = r_wmask;
  assign o_memory_data = r_mem_data;
  assign o_fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cpu_writeback_stage.sv
`default_nettype none
// =============================================================================
// tb_cpu_writeback_stage : directed self-checking bench for cpu_writeback_stage
// Revision 1.0 - initial release
// =============================================================================
module tb_cpu_writeback_stage;

  logic        i_clock;
  logic        i_reset;
  logic [75:0] i_execute_data;
  logic        o_busy;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic [38:0] o_memory_data;
  logic        o_fault;

  int total;
  int bad;
  int nbusy;

  cpu_writeback_stage dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_execute_data (i_execute_data),
    .o_busy         (o_busy),
    .o_bus_request  (o_bus_request),
    .o_bus_rw       (o_bus_rw),
    .o_bus_address  (o_bus_address),
    .o_bus_wdata    (o_bus_wdata),
    .o_bus_wmask    (o_bus_wmask),
    .i_bus_ready    (i_bus_ready),
    .i_bus_rdata    (i_bus_rdata),
    .o_memory_data  (o_memory_data),
    .o_fault        (o_fault)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [75:0] pkt(input logic s, input logic [5:0] rd,
                                      input logic [31:0] res, input logic [31:0] sd,
                                      input logic [2:0] f3, input logic mr, input logic mw);
    return {s, rd, res, sd, f3, mr, mw};
  endfunction

  // Entered at the negedge right after the accept edge; ready is sampled k edges later.
  task automatic bus_wait(input int k, input logic [31:0] rdata, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < k; i++) begin
      if (i > 0) @(negedge i_clock);
      if (o_busy) busy_cycles++;
      if (i == k - 1) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = rdata;
      end
    end
    @(posedge i_clock);
    @(negedge i_clock);
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    i_reset = 1'b1;
    i_execute_data = 76'd0;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_memdata", o_memory_data, 39'd0);
    chk("rst_req_busy", {o_bus_request, o_busy, o_bus_rw, o_fault}, 4'd0);
    chk("rst_bus", {o_bus_address, o_bus_wdata, o_bus_wmask}, 68'd0);
    i_reset = 1'b0;

    // ALU write-back, then hold while strobe is unchanged
    @(negedge i_clock);
    i_execute_data = pkt(1'b1, 6'd5, 32'hDEADBEEF, 32'd0, 3'd0, 1'b0, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("alu_wb", o_memory_data, {1'b1, 6'd5, 32'hDEADBEEF});
    @(negedge i_clock);
    chk("alu_hold", o_memory_data, {1'b1, 6'd5, 32'hDEADBEEF});

    // ALU with rd=0 consumes the strobe without writing back
    i_execute_data = pkt(1'b0, 6'd0, 32'h00001234, 32'd0, 3'd0, 1'b0, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("alu_rd0", o_memory_data, {1'b1, 6'd5, 32'hDEADBEEF});

    // LB from lane 3, ready after 3 cycles
    i_execute_data = pkt(1'b1, 6'd7, 32'h00001003, 32'd0, 3'b000, 1'b1, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("lb_req", {o_bus_request, o_busy, o_bus_rw}, 3'b110);
    chk("lb_addr", o_bus_address, 32'h00001000);
    chk("lb_wmask", o_bus_wmask, 4'd0);
    bus_wait(3, 32'h80112233, nbusy);
    chk("lb_busy_cycles", nbusy, 3);
    chk("lb_done", {o_bus_request, o_busy}, 2'b00);
    chk("lb_wb", o_memory_data, {1'b0, 6'd7, 32'hFFFFFF80});

    // LBU, ready in first request cycle
    i_execute_data = pkt(1'b0, 6'd7, 32'h00001003, 32'd0, 3'b100, 1'b1, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    bus_wait(1, 32'h80112233, nbusy);
    chk("lbu_busy_cycles", nbusy, 1);
    chk("lbu_wb", o_memory_data, {1'b1, 6'd7, 32'h00000080});

    // ready while idle must be ignored
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h55555555;
    @(posedge i_clock);
    @(negedge i_clock);
    i_bus_ready = 1'b0;
    chk("idle_ready", {o_busy, o_memory_data}, {1'b0, 1'b1, 6'd7, 32'h00000080});

    // SH upper half
    i_execute_data = pkt(1'b1, 6'd4, 32'h00002002, 32'h0000ABCD, 3'b001, 1'b0, 1'b1);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("sh_rw_req", {o_bus_rw, o_bus_request}, 2'b11);
    chk("sh_addr", o_bus_address, 32'h00002000);
    chk("sh_wdata", o_bus_wdata, 32'hABCDABCD);
    chk("sh_wmask", o_bus_wmask, 4'b1100);
    bus_wait(2, 32'd0, nbusy);
    chk("sh_busy_cycles", nbusy, 2);
    chk("sh_no_wb", {o_bus_request, o_memory_data}, {1'b0, 1'b1, 6'd7, 32'h00000080});

    // Misaligned LW: single fault pulse, no bus access
    i_execute_data = pkt(1'b0, 6'd9, 32'h00003001, 32'd0, 3'b010, 1'b1, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("lw_mis_fault", {o_fault, o_bus_request, o_busy}, 3'b100);
    @(negedge i_clock);
    chk("lw_mis_clear", {o_fault, o_bus_request, o_busy}, 3'b000);
    chk("lw_mis_no_wb", o_memory_data, {1'b1, 6'd7, 32'h00000080});

    // SB lane 1
    i_execute_data = pkt(1'b1, 6'd0, 32'h00000011, 32'h0000005A, 3'b000, 1'b0, 1'b1);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("sb_addr", o_bus_address, 32'h00000010);
    chk("sb_wdata", o_bus_wdata, 32'h5A5A5A5A);
    chk("sb_wmask", o_bus_wmask, 4'b0010);
    bus_wait(1, 32'd0, nbusy);

    // LW then ALU toggled during BUS: ordered, each write-back exactly once
    i_execute_data = pkt(1'b0, 6'd1, 32'h00000040, 32'd0, 3'b010, 1'b1, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("b2b_req", o_bus_request, 1'b1);
    i_execute_data = pkt(1'b1, 6'd2, 32'h12345678, 32'd0, 3'd0, 1'b0, 1'b0);
    bus_wait(2, 32'hCAFEF00D, nbusy);
    chk("b2b_load_wb", o_memory_data, {1'b0, 6'd1, 32'hCAFEF00D});
    @(negedge i_clock);
    chk("b2b_alu_wb", o_memory_data, {1'b1, 6'd2, 32'h12345678});
    @(negedge i_clock);
    chk("b2b_alu_once", {o_busy, o_memory_data}, {1'b0, 1'b1, 6'd2, 32'h12345678});

    // Reset in the middle of a load
    i_execute_data = pkt(1'b0, 6'd3, 32'h00000080, 32'd0, 3'b010, 1'b1, 1'b0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_mid_req", o_bus_request, 1'b1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_mid_drop", {o_bus_request, o_busy}, 2'b00);
    chk("rst_mid_outs", {o_memory_data, o_bus_address, o_bus_wmask}, 75'd0);
    i_execute_data = 76'd0;
    @(negedge i_clock);
    i_reset = 1'b0;
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hFFFFFFFF;
    @(posedge i_clock);
    @(negedge i_clock);
    i_bus_ready = 1'b0;
    chk("rst_mid_no_wb", {o_bus_request, o_memory_data}, 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
